receiver_uart: RTL and testbench

RECEIVER_UART -- requirements
Module: receiver_uart

---
 rtl/uart_pkg.sv | 34 +++
 rtl/baud_controller.sv | 34 +++
 rtl/receiver_uart.sv | 157 +++++++++++++++
 tb/tb_receiver_uart.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor table, FSM states, frame constants.
// Used by receiver_uart and transmitter_uart.
package uart_pkg;

   localparam int FRAME_BITS = 11;
   localparam int OVERSAMPLE = 16;
   localparam int DATA_BITS  = 8;
   localparam int DIV_W      = 14;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

   // Clocks per 16x sample tick at 50 MHz
   function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
      logic [DIV_W-1:0] d;
      case (sel)
         3'b000:  d = 14'd10417;
         3'b001:  d = 14'd2604;
         3'b010:  d = 14'd651;
         3'b011:  d = 14'd326;
         3'b100:  d = 14'd163;
         3'b101:  d = 14'd81;
         3'b110:  d = 14'd54;
         default: d = 14'd27;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/baud_controller.sv
// 16x oversample tick generator; one-clk sample_ENABLE pulse every baud_div(baud_select) clks.
module baud_controller
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       enable,
   output logic       sample_ENABLE
);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div;

   assign div = baud_div(baud_select);

   // >= so a switch to a shorter divisor cannot strand the counter above its wrap point
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt           <= '0;
         sample_ENABLE <= 1'b0;
      end else if (!enable) begin
         cnt           <= '0;
         sample_ENABLE <= 1'b0;
      end else if (cnt >= div - DIV_W'(1)) begin
         cnt           <= '0;
         sample_ENABLE <= 1'b1;
      end else begin
         cnt           <= cnt + DIV_W'(1);
         sample_ENABLE <= 1'b0;
      end
   end

endmodule

// File: rtl/receiver_uart.sv
// UART receiver: 8 data bits, even parity, 1 stop, 16x oversampling.
// Optional RX_MAJORITY_EN: 2-of-3 vote over ticks 6,7,8 instead of a single tick-7 sample.
module receiver_uart
   import uart_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       Rx_EN,
   input  logic       RxD,
   output logic [7:0] Rx_DATA,
   output logic       Rx_VALID,
   output logic       Rx_PERROR,
   output logic       Rx_FERROR
);

   localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_EN
   localparam logic [3:0] SAMPLE_TICK = 4'd8;
`else
   localparam logic [3:0] SAMPLE_TICK = 4'd7;
`endif

   uart_state_t state;
   logic        rx_s1, rx_sync;
   logic [2:0]  baud_q;
   logic        tick;
   logic [3:0]  tick_cnt, tick_nxt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shift;
   logic        perr;
   logic        brk;
   logic        bit_val;
   logic        sample;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_s1   <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_s1   <= RxD;
         rx_sync <= rx_s1;
      end
   end

   // Rate is only re-latched between frames so a mid-frame change cannot skew bit timing
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         baud_q <= 3'b000;
      else if (state == IDLE)
         baud_q <= baud_select;
   end

   baud_controller u_baud (
      .clk           (clk),
      .reset         (reset),
      .baud_select   (baud_q),
      .enable        (Rx_EN),
      .sample_ENABLE (tick)
   );

   // tick_cnt holds the index of the last tick seen; the entry tick of START is tick 0
   assign tick_nxt = tick_cnt + 4'd1;
   assign sample   = (tick_nxt == SAMPLE_TICK);

`ifdef RX_MAJORITY_EN
   logic [1:0] early;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         early <= 2'b11;
      else if (tick && state != IDLE) begin
         if (tick_nxt == 4'd6) early[1] <= rx_sync;
         if (tick_nxt == 4'd7) early[0] <= rx_sync;
      end
   end

   assign bit_val = (early[1] & early[0]) | (early[1] & rx_sync) | (early[0] & rx_sync);
`else
   assign bit_val = rx_sync;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         perr      <= 1'b0;
         brk       <= 1'b0;
         Rx_DATA   <= 8'h00;
         Rx_VALID  <= 1'b0;
         Rx_PERROR <= 1'b0;
         Rx_FERROR <= 1'b0;
      end else begin
         Rx_VALID <= 1'b0;
         if (!Rx_EN) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
         end else if (tick) begin
            tick_cnt <= tick_nxt;
            case (state)
               IDLE: begin
                  tick_cnt <= '0;
                  // After a framing error the line must be seen high before a new start is accepted
                  if (brk) begin
                     if (rx_sync) brk <= 1'b0;
                  end else if (!rx_sync) begin
                     state <= START;
                  end
               end
               START: begin
                  if (sample && bit_val) begin
                     state    <= IDLE;
                     tick_cnt <= '0;
                  end else if (tick_nxt == LAST_TICK) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  if (sample)
                     shift <= {bit_val, shift[7:1]};
                  if (tick_nxt == LAST_TICK) begin
                     bit_cnt <= bit_cnt + 3'd1;
                     if (bit_cnt == 3'(DATA_BITS - 1))
                        state <= PARITY;
                  end
               end
               PARITY: begin
                  if (sample)
                     perr <= ^{shift, bit_val};
                  if (tick_nxt == LAST_TICK)
                     state <= STOP;
               end
               STOP: begin
                  if (sample) begin
                     Rx_DATA   <= shift;
                     Rx_PERROR <= perr;
                     Rx_FERROR <= !bit_val;
                     Rx_VALID  <= !perr && bit_val;
                     brk       <= !bit_val;
                     state     <= IDLE;
                     tick_cnt  <= '0;
                  end
               end
               default: begin
                  state    <= IDLE;
                  tick_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_receiver_uart.sv
// Scoreboard bench for receiver_uart: serial frames are generated from a byte-level model,
// expected results are queued, and a monitor compares each output event.
module tb_receiver_uart;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] baud_select;
   logic       Rx_EN;
   logic       RxD;
   logic [7:0] Rx_DATA;
   logic       Rx_VALID, Rx_PERROR, Rx_FERROR;

   receiver_uart dut (
      .clk         (clk),
      .reset       (reset),
      .baud_select (baud_select),
      .Rx_EN       (Rx_EN),
      .RxD         (RxD),
      .Rx_DATA     (Rx_DATA),
      .Rx_VALID    (Rx_VALID),
      .Rx_PERROR   (Rx_PERROR),
      .Rx_FERROR   (Rx_FERROR)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic       vld;
      logic [7:0] data;
      logic       pe;
      logic       fe;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   bit_clks = 432;

   // Byte-level view of what the receiver should currently be showing
   logic [7:0] m_data = 8'h00;
   logic       m_pe = 1'b0, m_fe = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic hold_line(input logic v, input int n);
      RxD = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_data"},  32'(Rx_DATA),   32'h00);
      check({tag, "_valid"}, 32'(Rx_VALID),  32'h0);
      check({tag, "_perr"},  32'(Rx_PERROR), 32'h0);
      check({tag, "_ferr"},  32'(Rx_FERROR), 32'h0);
   endtask

   // pflip=1 sends the wrong parity; stop_bit=0 sends a framing error, optionally followed by a low tail
   task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop_bit, input int low_tail);
      logic p;
      exp_t e;
      p      = (^d) ^ pflip;
      e.data = d;
      e.pe   = (^{d, p});
      e.fe   = !stop_bit;
      e.vld  = !e.pe && !e.fe;
      q.push_back(e);
      m_data = d; m_pe = e.pe; m_fe = e.fe;
      hold_line(1'b0, bit_clks);
      for (int i = 0; i < 8; i++) hold_line(d[i], bit_clks);
      hold_line(p, bit_clks);
      hold_line(stop_bit, bit_clks);
      if (!stop_bit && low_tail > 0) hold_line(1'b0, low_tail);
      hold_line(1'b1, 150 + int'($urandom_range(0, 60)));
   endtask

   // Monitor: an output event is a VALID pulse or any change of the held result registers
   initial begin
      logic [9:0] prev;
      exp_t       e;
      prev = 10'h000;
      forever begin
         @(negedge clk);
         if (reset === 1'b1) begin
            prev = {Rx_DATA, Rx_PERROR, Rx_FERROR};
         end else if (Rx_VALID === 1'b1 || {Rx_DATA, Rx_PERROR, Rx_FERROR} != prev) begin
            prev = {Rx_DATA, Rx_PERROR, Rx_FERROR};
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_output: valid=%b data=%h perr=%b ferr=%b with nothing expected at %0t",
                        Rx_VALID, Rx_DATA, Rx_PERROR, Rx_FERROR, $time);
            end else begin
               e = q.pop_front();
               check("rx_valid", 32'(Rx_VALID),  32'(e.vld));
               check("rx_data",  32'(Rx_DATA),   32'(e.data));
               check("rx_perr",  32'(Rx_PERROR), 32'(e.pe));
               check("rx_ferr",  32'(Rx_FERROR), 32'(e.fe));
            end
         end
      end
   end

   initial begin
      logic [7:0] d;
      logic       pf, sb;
      reset = 1'b1; Rx_EN = 1'b1; RxD = 1'b1; baud_select = 3'b111;
      repeat (5) @(posedge clk);
      #1;
      check_reset_values("reset");
      reset = 1'b0;
      hold_line(1'b1, 100);

      send_frame(8'hA8, 1'b0, 1'b1, 0);     // good
      send_frame(8'h88, 1'b1, 1'b1, 0);     // parity bit 1 on even-weight byte
      send_frame(8'h55, 1'b0, 1'b0, 0);     // stop bit 0
      send_frame(8'h55, 1'b0, 1'b1, 0);     // good, clears framing flag

      hold_line(1'b0, 100);                 // glitch shorter than half a bit
      hold_line(1'b1, 600);

      // reset in the middle of D3, then a full frame
      d = 8'h3C;
      hold_line(1'b0, bit_clks);
      for (int i = 0; i < 3; i++) hold_line(d[i], bit_clks);
      hold_line(d[3], bit_clks / 2);
      reset = 1'b1;
      #2;
      check_reset_values("async_reset");
      m_data = 8'h00; m_pe = 1'b0; m_fe = 1'b0;
      hold_line(d[3], 5);
      hold_line(1'b1, 5);
      reset = 1'b0;
      hold_line(1'b1, 600);
      send_frame(8'h3C, 1'b0, 1'b1, 0);

      // break: all-low frame held low for three more bit times
      send_frame(8'h00, 1'b0, 1'b0, 3 * bit_clks);

      // enable dropped mid-frame: silent abort
      hold_line(1'b0, bit_clks);
      hold_line(1'b1, bit_clks);
      hold_line(1'b0, bit_clks / 2);
      Rx_EN = 1'b0;
      hold_line(1'b0, bit_clks / 2);
      hold_line(1'b1, 300);
      Rx_EN = 1'b1;
      hold_line(1'b1, 300);
      send_frame(8'hC3, 1'b0, 1'b1, 0);

      // rate change requested mid-frame must not disturb it
      fork
         send_frame(8'h6E, 1'b0, 1'b1, 0);
         begin
            repeat (3 * 432) @(posedge clk);
            baud_select = 3'b000;
            repeat (6 * 432) @(posedge clk);
            baud_select = 3'b111;
         end
      join

      // 57600 baud
      baud_select = 3'b110;
      hold_line(1'b1, 200);
      bit_clks = 864;
      send_frame(8'h91, 1'b0, 1'b1, 0);
      bit_clks = 432;
      baud_select = 3'b111;
      hold_line(1'b1, 200);

      // transmitter-style byte stream
      send_frame(8'hA8, 1'b0, 1'b1, 0);
      send_frame(8'h88, 1'b0, 1'b1, 0);

      for (int n = 0; n < 2; n++) begin
         d  = 8'($urandom);
         pf = ($urandom_range(0, 3) == 0);
         sb = ($urandom_range(0, 3) != 0);
         // an error frame that leaves the held registers unchanged would be invisible
         if ((pf || !sb) && d == m_data && ((^{d, (^d) ^ pf}) == m_pe) && (!sb == m_fe)) begin
            pf = 1'b0;
            sb = 1'b1;
         end
         send_frame(d, pf, sb, 0);
      end

      for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
